output_display_mux: RTL and testbench
=====================================

Name: output_display_mux

Overview:
Parametrised output port for the bus-based computer. It latches a bus word on OI and converts it to BCD with a sequential shift-add-3 (double-dabble) engine, one bit per clock. It drives a time-multiplexed common-segment 7-segment display, with one digit enabled at a time. Unsigned and two's-complement signed display modes are supported.

Parameters:
DATA_W, 8, width of bus and output register
DIGITS, 3, number of displayed decimal digits (2..8)
SCAN_DIV, 1000, clock cycles each digit stays enabled (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset
bus  inout  DATA_W  system bus; block only reads it and drives it high-Z permanently
OI  input  1  output-in: latch bus on rising clk while high
SM  input  1  signed mode, sampled together with bus on OI
busy  output  1  high while a conversion is in progress
seg  output  7  segment pattern, seg[0]=a .. seg[6]=g, 1 = lit
an  output  DIGITS  one-hot digit enable, an[0] = units
neg  output  1  minus indicator for the displayed value

Behaviour:
- Reset (rst==0 at a clk edge) clears everything and aborts any conversion:
  - value, pending flag, BCD shadow and display registers = 0.
  - busy=0, neg=0, scan counter=0, digit index=0.
  - an=1 (units enabled), seg=7'b0111111 (digit '0').
- Load, idle case (OI=1, busy=0):
  - Latch bus into the shift register and SM into mode.
  - If SM=1 and bus[DATA_W-1]=1, shift in the two's-complement magnitude instead and set the pending sign.
  - busy=1 on the next cycle.
  - Magnitude of the most negative value (e.g. -128 for DATA_W=8) is 2^(DATA_W-1), which is exact.
- Conversion:
  - Exactly DATA_W iterations, one per clock.
  - Each iteration adds 3 to every BCD nibble >=5, then shifts left one bit, taking the magnitude MSB into the BCD LSB.
  - busy is high for exactly DATA_W cycles.
  - On the final iteration, the BCD result and sign are copied atomically into the display registers and neg. busy falls the following cycle.
  - The display never shows partial results.
- Load while busy (OI=1, busy=1):
  - bus/SM are captured into a pending register; the current conversion is not disturbed.
  - Multiple loads while busy: last write wins.
  - On completion, the pending value starts the next conversion immediately. busy stays high and the pending flag clears.
- Overflow: if the value needs more than DIGITS digits, upper digits are dropped (display shows value mod 10^DIGITS). No error flag.
- Scan:
  - The scan counter runs 0..SCAN_DIV-1 continuously, independent of busy.
  - When the counter wraps, the digit index advances 0..DIGITS-1 and wraps to 0.
  - an = one-hot(index), registered.
  - seg = 7-seg decode of display digit[index], registered together with an so both change on the same edge.
- Decode table (seg[6:0], digits 0..9): 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F. Nibbles >9 cannot occur; decode them to 00.
- neg is level-valid continuously and is not multiplexed.

Optional Feature:
Macro OUTPUT_DISPLAY_LZB_EN.
- Defined: leading-zero blanking.
  - Any digit above the most-significant nonzero digit outputs seg=0 while enabled.
  - The units digit is never blanked, so value 0 shows '0'.
  - The blank mask is computed at display-register update, not per scan.
- Undefined: all DIGITS digits are always shown, including leading zeros.

Test Plan:
1. rst=0 for 2 cycles, then release -> busy=0, neg=0, an=001, seg=3F. Verify rst held 1 does not reset, then low-level reset is synchronous (no async effect between edges).
2. DATA_W=8, SM=0, bus=255, OI pulse -> busy high exactly 8 cycles; display digits {2,5,5}; scan at SCAN_DIV=4 yields an=001/seg=6D, 010/6D, 100/5B, each held 4 cycles, then repeats.
3. SM=1, bus=8'h80 -> digits {1,2,8}, neg=1. Then SM=1, bus=8'hFF -> digits {0,0,1}, neg=1. Then SM=0, bus=8'hFF -> digits {2,5,5}, neg=0.
4. Load 100, then OI pulses with 37 and then 42 during busy -> display shows 100, then 042 with no intermediate 037; busy high continuously for 16 cycles.
5. Start a conversion of 200, assert rst at cycle 4 of busy -> display 000, busy=0 next cycle; the old value never appears.
6. OUTPUT_DISPLAY_LZB_EN defined, load 7 -> an=100 and an=010 give seg=00; an=001 gives seg=07. Load 0 -> units seg=3F.

Source files
------------

// File: rtl/output_display_mux.sv
// ============================================================================
// Module   : output_display_mux
// Purpose  : Bus output port with sequential binary-to-BCD conversion that
//            drives a multiplexed 7-segment display. Optional leading-zero
//            blanking when OUTPUT_DISPLAY_LZB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module output_display_mux #(
  parameter int DATA_W   = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] bus,
  input  logic              OI,
  input  logic              SM,
  output logic              busy,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              neg
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = $clog2(DIGITS);
`ifdef OUTPUT_DISPLAY_LZB_EN
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};
`else
  localparam logic [DIGITS-1:0] BLANK_RST = '0;
`endif

  // The block only listens to the bus.
  assign bus = {DATA_W{1'bz}};

  logic [DATA_W-1:0] shreg, pend_val, in_mag, sh_nxt;
  logic [BCD_W-1:0]  bcd, bcd_nxt, adj, disp;
  logic [BCD_W+DATA_W-1:0] shifted;
  logic [CNT_W-1:0]  iter;
  logic              sign, pend_sign, pend_flag, in_neg, last_iter;
  logic [SCAN_W-1:0] scan_cnt;
  logic              scan_wrap;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [DIGITS-1:0] blank, blank_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  // Signed negative inputs are converted as their magnitude; -2^(W-1) maps exactly.
  assign in_neg    = SM & bus[DATA_W-1];
  assign in_mag    = in_neg ? (~bus + 1'b1) : bus;
  assign last_iter = busy && (iter == CNT_W'(DATA_W - 1));

  always_comb begin
    adj = bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd[4*k +: 4] > 4'd4) adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
    shifted = {adj, shreg} << 1;
    bcd_nxt = shifted[BCD_W+DATA_W-1 -: BCD_W];
    sh_nxt  = shifted[DATA_W-1:0];
  end

`ifdef OUTPUT_DISPLAY_LZB_EN
  logic zero_run;
  always_comb begin
    blank_nxt = '0;
    zero_run  = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_run     = zero_run & (bcd_nxt[4*k +: 4] == 4'd0);
      blank_nxt[k] = zero_run;
    end
  end
`else
  assign blank_nxt = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg     <= '0;
      bcd       <= '0;
      iter      <= '0;
      sign      <= 1'b0;
      busy      <= 1'b0;
      pend_val  <= '0;
      pend_sign <= 1'b0;
      pend_flag <= 1'b0;
      disp      <= '0;
      neg       <= 1'b0;
      blank     <= BLANK_RST;
    end else if (OI && !busy) begin
      shreg <= in_mag;
      sign  <= in_neg;
      bcd   <= '0;
      iter  <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      shreg <= sh_nxt;
      bcd   <= bcd_nxt;
      iter  <= iter + 1'b1;
      if (OI) begin
        pend_val  <= in_mag;
        pend_sign <= in_neg;
        pend_flag <= 1'b1;
      end
      if (last_iter) begin
        // Result, sign and blank mask change together so no partial value shows.
        disp  <= bcd_nxt;
        neg   <= sign;
        blank <= blank_nxt;
        bcd   <= '0;
        iter  <= '0;
        if (OI) begin
          shreg     <= in_mag;
          sign      <= in_neg;
          pend_flag <= 1'b0;
        end else if (pend_flag) begin
          shreg     <= pend_val;
          sign      <= pend_sign;
          pend_flag <= 1'b0;
        end else begin
          busy <= 1'b0;
        end
      end
    end
  end

  assign scan_wrap = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

  always_comb begin
    idx_nxt = idx;
    if (scan_wrap) idx_nxt = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
  end

  // an and seg are both derived from the next index so they switch on one edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      an       <= DIGITS'(1);
      seg      <= 7'h3F;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      idx      <= idx_nxt;
      an       <= DIGITS'(1) << idx_nxt;
      seg      <= blank[idx_nxt] ? 7'h00 : seg_decode(disp[4*idx_nxt +: 4]);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_output_display_mux.sv
// ============================================================================
// Module   : tb_output_display_mux
// Purpose  : Scoreboard bench for output_display_mux (honours
//            OUTPUT_DISPLAY_LZB_EN when defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_output_display_mux;
  localparam int DATA_W   = 8;
  localparam int DIGITS   = 3;
  localparam int SCAN_DIV = 4;

  logic clk = 1'b0, rst = 1'b0, OI = 1'b0, SM = 1'b0;
  logic [DATA_W-1:0] bus_drv = '0;
  wire  [DATA_W-1:0] bus;
  logic busy, neg;
  logic [6:0] seg;
  logic [DIGITS-1:0] an;

  assign bus = bus_drv;

  output_display_mux #(.DATA_W(DATA_W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .bus(bus), .OI(OI), .SM(SM),
    .busy(busy), .seg(seg), .an(an), .neg(neg)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int mag; bit sgn; } exp_t;
  exp_t q[$];
  exp_t cur;
  int   end_cyc = -100;
  bit   pend_v  = 1'b0;
  int   seg_tab[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

  function automatic int pow10(int k);
    int p = 1;
    for (int i = 0; i < k; i++) p *= 10;
    return p;
  endfunction

  function automatic exp_t mk(logic [DATA_W-1:0] v, bit sm);
    exp_t e;
    int m = int'(v);
    e.sgn = sm && v[DATA_W-1];
    if (e.sgn) m = (1 << DATA_W) - m;
    e.mag = m % pow10(DIGITS);
    return e;
  endfunction

  function automatic int exp_seg(exp_t e, int k);
    int d = (e.mag / pow10(k)) % 10;
`ifdef OUTPUT_DISPLAY_LZB_EN
    if (k > 0 && e.mag < pow10(k)) return 0;
`endif
    return seg_tab[d];
  endfunction

  // Timing model: a conversion loaded at edge L completes at edge L+DATA_W;
  // loads seen while converting overwrite a single pending slot.
  function automatic void model_load(int L, exp_t e);
    if (pend_v && L > end_cyc) begin
      end_cyc += DATA_W;
      pend_v   = 1'b0;
    end
    if (L > end_cyc) begin
      q.push_back(e);
      end_cyc = L + DATA_W;
    end else if (L == end_cyc) begin
      if (pend_v) q[$] = e; else q.push_back(e);
      pend_v  = 1'b0;
      end_cyc = L + DATA_W;
    end else begin
      if (pend_v) q[$] = e; else q.push_back(e);
      pend_v = 1'b1;
    end
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: detects completions from busy run length and checks the display.
  logic rst_q = 1'b1;
  bit   started = 1'b0, skip = 1'b0;
  int   bc = 0, run = 0;
  logic [DIGITS-1:0] an_prev = '0;

  always @(negedge clk) begin
    int k;
    if (!rst_q) begin
      started = 1'b1;
      bc = 0; skip = 1'b0; run = 1; an_prev = an;
      cur.mag = 0; cur.sgn = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_neg", 32'(neg), 32'd0);
      chk("rst_an", 32'(an), 32'd1);
      chk("rst_seg", 32'(seg), 32'h3F);
    end else if (started) begin
      if (bc == DATA_W) begin
        bc = 0;
        if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          cur  = q.pop_front();
          skip = 1'b1;
        end
      end
      if (busy) bc++;
      else if (bc != 0) begin
        chk("busy_len", 32'(bc), 32'(DATA_W));
        bc = 0;
      end
      if (an == an_prev) run++;
      else begin
        chk("scan_hold", 32'(run), 32'(SCAN_DIV));
        chk("scan_order", 32'(an), 32'({an_prev[DIGITS-2:0], an_prev[DIGITS-1]}));
        run = 1;
      end
      an_prev = an;
      chk("neg", 32'(neg), 32'(cur.sgn));
      if (skip) skip = 1'b0;
      else begin
        k = -1;
        for (int i = 0; i < DIGITS; i++) if (an == (DIGITS'(1) << i)) k = i;
        if (k < 0) chk("an_onehot", 32'(an), 32'd0);
        else chk("seg", 32'(seg), 32'(exp_seg(cur, k)));
      end
    end
    rst_q = rst;
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(logic [DATA_W-1:0] v, bit sm);
    bus_drv = v;
    SM      = sm;
    OI      = 1'b1;
    model_load(cyc + 1, mk(v, sm));
    tick();
    OI      = 1'b0;
    bus_drv = DATA_W'($urandom);
    SM      = 1'($urandom);
  endtask

  task automatic do_reset(int n);
    rst = 1'b0;
    tick(n);
    q.delete();
    end_cyc = -100;
    pend_v  = 1'b0;
    rst     = 1'b1;
  endtask

  initial begin
    tick(3);
    rst = 1'b1;
    tick(6);
    load(8'd255, 1'b0);                 // unsigned max, full scan observed
    tick(30);
    load(8'h80, 1'b1);                  // most negative value
    tick(14);
    load(8'hFF, 1'b1);
    tick(14);
    load(8'hFF, 1'b0);
    tick(20);
    load(8'd100, 1'b0);                 // pending: 37 overwritten by 42
    tick(2);
    load(8'd37, 1'b0);
    tick(1);
    load(8'd42, 1'b0);
    tick(30);
    load(8'd200, 1'b0);                 // reset aborts mid-conversion
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sync", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    q.delete();
    end_cyc = -100;
    pend_v  = 1'b0;
    rst     = 1'b1;
    tick(20);
    load(8'd7, 1'b0);
    tick(20);
    load(8'd0, 1'b0);
    tick(20);
    for (int i = 0; i < 80; i++) begin
      tick($urandom_range(0, 12));
      if ($urandom_range(0, 19) == 0) do_reset($urandom_range(1, 2));
      else load(DATA_W'($urandom), 1'($urandom_range(0, 1)));
    end
    tick(40);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
